// File: rtl/ext_irq_gateway.sv
// rtl/ext_irq_gateway.sv - external interrupt gateway: synchronize, detect, pend, claim/complete
// Lowest enabled pending index wins a claim; a source re-arms only after its completion.
module ext_irq_gateway #(
  parameter int N_SRC       = 8,
  parameter int SYNC_STAGES = 2,
  localparam int IDW        = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src_i,
  input  logic [N_SRC-1:0] cfg_en_i,
  input  logic [N_SRC-1:0] cfg_edge_i,
  output logic             irq_o,
  input  logic             claim_i,
  output logic             claim_valid_o,
  output logic [IDW-1:0]   claim_id_o,
  input  logic             complete_i,
  input  logic [IDW-1:0]   complete_id_i,
  output logic [N_SRC-1:0] pending_o
);

  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] sync_d [SYNC_STAGES];
  logic [N_SRC-1:0] prev_q, prev_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] in_service_q, in_service_d;
  logic             irq_q, irq_d;
  logic             claim_valid_q, claim_valid_d;
  logic [IDW-1:0]   claim_id_q, claim_id_d;

  logic [N_SRC-1:0] sync, rise, req, avail;
  logic [N_SRC-1:0] set_mask, claim_mask, done_mask;
  logic             win_found;
  logic [IDW-1:0]   win_id;

  always_comb begin
    sync_d[0] = irq_src_i;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
    sync   = sync_q[SYNC_STAGES-1];
    prev_d = sync;
    rise   = sync & ~prev_q;
    req    = (cfg_edge_i & rise) | (~cfg_edge_i & sync);
    avail  = pending_q & cfg_en_i;

    // Scan from the top so the lowest index is the last (winning) assignment.
    win_found = 1'b0;
    win_id    = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (avail[i]) begin
        win_found = 1'b1;
        win_id    = IDW'(i);
      end
    end

    claim_mask = '0;
    if (claim_i && win_found) begin
      claim_mask[win_id] = 1'b1;
    end

    done_mask = '0;
    if (complete_i && (32'(complete_id_i) < N_SRC)) begin
      done_mask[complete_id_i] = in_service_q[complete_id_i];
    end

    // Checks use the current registers, so a same-cycle complete or claim drops the req.
    set_mask      = req & ~pending_q & ~in_service_q;
    pending_d     = (pending_q | set_mask) & ~claim_mask;
    in_service_d  = (in_service_q | claim_mask) & ~done_mask;
    irq_d         = |avail;
    claim_valid_d = claim_i & win_found;
    claim_id_d    = claim_valid_d ? win_id : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      prev_q        <= '0;
      pending_q     <= '0;
      in_service_q  <= '0;
      irq_q         <= 1'b0;
      claim_valid_q <= 1'b0;
      claim_id_q    <= '0;
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      prev_q        <= prev_d;
      pending_q     <= pending_d;
      in_service_q  <= in_service_d;
      irq_q         <= irq_d;
      claim_valid_q <= claim_valid_d;
      claim_id_q    <= claim_id_d;
    end
  end

  assign irq_o         = irq_q;
  assign claim_valid_o = claim_valid_q;
  assign claim_id_o    = claim_id_q;
  assign pending_o     = pending_q;

endmodule

// File: tb/tb_ext_irq_gateway.sv
// tb/tb_ext_irq_gateway.sv - scoreboard bench for ext_irq_gateway
// Driver steps a reference model and queues expected outputs; a monitor compares them.
module tb_ext_irq_gateway;

  localparam int N = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] irq_src, cfg_en, cfg_edge;
  logic         claim, complete;
  logic [2:0]   complete_id;
  logic         irq_o, claim_valid_o;
  logic [2:0]   claim_id_o;
  logic [N-1:0] pending_o;

  ext_irq_gateway #(.N_SRC(N), .SYNC_STAGES(S)) dut (
    .clk           (clk),
    .rst           (rst),
    .irq_src_i     (irq_src),
    .cfg_en_i      (cfg_en),
    .cfg_edge_i    (cfg_edge),
    .irq_o         (irq_o),
    .claim_i       (claim),
    .claim_valid_o (claim_valid_o),
    .claim_id_o    (claim_id_o),
    .complete_i    (complete),
    .complete_id_i (complete_id),
    .pending_o     (pending_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       cv;
    bit [2:0] id;
    bit       chk_id;
    bit       irq;
    bit [7:0] pend;
  } exp_t;

  exp_t     expq[$];
  int       total = 0;
  int       bad = 0;

  // Model state: samples of irq_src taken at past edges (index 0 = newest).
  bit [7:0] hist [0:S];
  bit [7:0] m_pend, m_insvc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    exp_t     e;
    bit [7:0] sync_v, prev_v, req, np, ni;
    int       w;
    e = '{default: 0};
    if (rst) begin
      for (int j = 0; j <= S; j++) hist[j] = '0;
      m_pend  = '0;
      m_insvc = '0;
      e.chk_id = 1'b1;
    end else begin
      sync_v = hist[S-1];
      prev_v = hist[S];
      for (int i = 0; i < N; i++)
        req[i] = cfg_edge[i] ? (sync_v[i] && !prev_v[i]) : sync_v[i];
      e.irq = |(m_pend & cfg_en);
      w = -1;
      if (claim)
        for (int i = 0; i < N; i++)
          if (w < 0 && m_pend[i] && cfg_en[i]) w = i;
      np = m_pend;
      ni = m_insvc;
      for (int i = 0; i < N; i++)
        if (req[i] && !m_pend[i] && !m_insvc[i]) np[i] = 1'b1;
      if (w >= 0) begin
        np[w] = 1'b0;
        ni[w] = 1'b1;
      end
      if (complete && m_insvc[complete_id]) ni[complete_id] = 1'b0;
      e.cv     = (w >= 0);
      e.id     = (w >= 0) ? 3'(w) : 3'd0;
      e.chk_id = claim;
      for (int j = S; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = irq_src;
      m_pend  = np;
      m_insvc = ni;
    end
    e.pend = m_pend;
    expq.push_back(e);
  endtask

  task automatic drive(input bit r, input bit [7:0] s, input bit [7:0] en, input bit [7:0] ed,
                       input bit c, input bit cm, input bit [2:0] ci);
    rst = r; irq_src = s; cfg_en = en; cfg_edge = ed;
    claim = c; complete = cm; complete_id = ci;
    @(posedge clk);
    #1;
    model_step();
  endtask

  function automatic bit [2:0] pick_cid();
    bit [2:0] c;
    c = 3'($urandom_range(0, 7));
    if ($urandom_range(0, 9) < 7)
      for (int k = 0; k < 8; k++)
        if (m_insvc[3'(c + 3'(k))]) return 3'(c + 3'(k));
    return c;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("claim_valid", 32'(claim_valid_o), 32'(e.cv));
        if (e.cv || e.chk_id) chk("claim_id", 32'(claim_id_o), 32'(e.id));
        chk("irq", 32'(irq_o), 32'(e.irq));
        chk("pending", 32'(pending_o), 32'(e.pend));
      end
    end
  end

  initial begin : driver
    bit [7:0] src, en, ed;
    repeat (3) drive(1, 0, 8'hFF, 8'hFF, 0, 0, 0);
    // src3 one-cycle pulse in edge mode, then a claim once irq is up
    drive(0, 8'h08, 8'hFF, 8'hFF, 0, 0, 0);
    repeat (4) drive(0, 0, 8'hFF, 8'hFF, 0, 0, 0);
    drive(0, 0, 8'hFF, 8'hFF, 1, 0, 0);
    repeat (2) drive(0, 0, 8'hFF, 8'hFF, 0, 0, 0);
    // src1 and src6 together: three claims
    drive(0, 8'h42, 8'hFF, 8'hFF, 0, 0, 0);
    repeat (4) drive(0, 0, 8'hFF, 8'hFF, 0, 0, 0);
    repeat (3) drive(0, 0, 8'hFF, 8'hFF, 1, 0, 0);
    // level src5 held: claim, complete, re-pend
    repeat (5) drive(0, 8'h20, 8'hFF, 8'h00, 0, 0, 0);
    drive(0, 8'h20, 8'hFF, 8'h00, 1, 0, 0);
    drive(0, 8'h20, 8'hFF, 8'h00, 0, 1, 3'd5);
    repeat (3) drive(0, 8'h20, 8'hFF, 8'h00, 0, 0, 0);
    // src2 pending but disabled, then enabled
    drive(1, 0, 8'hFB, 8'hFF, 0, 0, 0);
    drive(0, 8'h04, 8'hFB, 8'hFF, 0, 0, 0);
    repeat (4) drive(0, 0, 8'hFB, 8'hFF, 0, 0, 0);
    drive(0, 0, 8'hFB, 8'hFF, 1, 0, 0);
    repeat (2) drive(0, 0, 8'hFF, 8'hFF, 0, 0, 0);
    // reset with everything pending and two sources in service
    drive(0, 8'hFF, 8'hFF, 8'h00, 0, 0, 0);
    repeat (3) drive(0, 8'hFF, 8'hFF, 8'h00, 0, 0, 0);
    repeat (2) drive(0, 8'hFF, 8'hFF, 8'h00, 1, 0, 0);
    drive(1, 8'hFF, 8'hFF, 8'h00, 0, 0, 0);
    repeat (4) drive(0, 8'h00, 8'hFF, 8'h00, 0, 0, 0);

    src = '0;
    for (int p = 0; p < 4; p++) begin
      ed = (p == 0) ? 8'hFF : (p == 1) ? 8'h00 : 8'($urandom);
      en = (p < 2) ? 8'hFF : 8'($urandom);
      for (int c = 0; c < 300; c++) begin
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, 7) == 0) src[i] = ~src[i];
        if (p >= 2 && $urandom_range(0, 15) == 0) en = 8'($urandom);
        if (p == 3 && $urandom_range(0, 31) == 0) ed = 8'($urandom);
        drive((p == 3) && ($urandom_range(0, 149) == 0), src, en, ed,
              $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, pick_cid());
      end
    end
    drive(0, 0, 8'hFF, 8'hFF, 0, 0, 0);

    repeat (3) @(negedge clk);
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d left expected 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
